// File: rtl/hsv2rgb_pkg.sv
// Shared constants and sector helper for the HSV->RGB converter.
package hsv2rgb_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned PROD_W   = 16;
    localparam int unsigned REGION_W = 3;

    // Hue circle is 256 codes split into six 43-code sectors (last one short).
    localparam int unsigned SECTOR_W  = 43;
    localparam int unsigned THR_1     = SECTOR_W * 1;
    localparam int unsigned THR_2     = SECTOR_W * 2;
    localparam int unsigned THR_3     = SECTOR_W * 3;
    localparam int unsigned THR_4     = SECTOR_W * 4;
    localparam int unsigned THR_5     = SECTOR_W * 5;
    localparam int unsigned REM_SCALE = 6;

    localparam int unsigned HSV2RGB_LATENCY = 5;

    typedef struct packed {
        logic [REGION_W-1:0] region;
        logic [PIX_W-1:0]    rem;
    } sector_t;

    // Sector index by threshold compare, and the scaled position inside it.
    function automatic sector_t hsv_sector(input logic [PIX_W-1:0] h);
        sector_t          sec;
        logic [PIX_W-1:0] base;
        if (h >= PIX_W'(THR_5)) begin
            sec.region = REGION_W'(5);
            base       = PIX_W'(THR_5);
        end else if (h >= PIX_W'(THR_4)) begin
            sec.region = REGION_W'(4);
            base       = PIX_W'(THR_4);
        end else if (h >= PIX_W'(THR_3)) begin
            sec.region = REGION_W'(3);
            base       = PIX_W'(THR_3);
        end else if (h >= PIX_W'(THR_2)) begin
            sec.region = REGION_W'(2);
            base       = PIX_W'(THR_2);
        end else if (h >= PIX_W'(THR_1)) begin
            sec.region = REGION_W'(1);
            base       = PIX_W'(THR_1);
        end else begin
            sec.region = REGION_W'(0);
            base       = PIX_W'(0);
        end
        // Offset is at most 42, so the x6 result fits in 8 bits (max 252).
        sec.rem = PIX_W'((h - base) * PIX_W'(REM_SCALE));
        return sec;
    endfunction

endpackage

// File: rtl/hsv2rgb_umul8x8.sv
// Registered 8x8 -> 16 unsigned multiplier, one clock of latency.
// Ports: clock; a, b operands; p registered product.
module umul8x8
    import hsv2rgb_pkg::*;
(
    input  logic              clock,
    input  logic [PIX_W-1:0]  a,
    input  logic [PIX_W-1:0]  b,
    output logic [PROD_W-1:0] p
);

    always_ff @(posedge clock) begin
        p <= PROD_W'(a) * PROD_W'(b);
    end

endmodule

// File: rtl/hsv2rgb.sv
// Pipelined HSV -> RGB converter, 5-clock latency, one sample per clock.
// Ports: clock, reset (sync, active-high); in_valid/h/s/v/in_tag sample in;
//        out_valid/r/g/b/out_tag result out, held while out_valid is low.
module hsv2rgb
    import hsv2rgb_pkg::*;
#(
    parameter int unsigned TAG_W = 21
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       h,
    input  logic [7:0]       s,
    input  logic [7:0]       v,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [7:0]       r,
    output logic [7:0]       g,
    output logic [7:0]       b,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned LAT = HSV2RGB_LATENCY;

    logic [LAT-1:0]   valid_sr;
    logic [TAG_W-1:0] tag_sr [LAT-1];

    // S1 input registers
    logic [PIX_W-1:0] s1_h, s1_s, s1_v;
    // S2 sector decode
    logic [PIX_W-1:0]    s2_v, s2_s, s2_s_inv, s2_rem, s2_rem_inv;
    logic [REGION_W-1:0] s2_region;
    logic                s2_zero;
    sector_t             sec_c;
    // S3 first products
    logic [PROD_W-1:0]   s_rem_prod, s_nrem_prod, v_sinv_prod;
    logic [PIX_W-1:0]    s3_v;
    logic [REGION_W-1:0] s3_region;
    logic                s3_zero;
    // S4 second products
    logic [PROD_W-1:0]   q_prod, t_prod;
    logic [PIX_W-1:0]    s4_v, s4_p;
    logic [REGION_W-1:0] s4_region;
    logic                s4_zero;
    // S5 mux
    logic [PIX_W-1:0]    r_c, g_c, b_c, q_c, t_c;

    // Only the high byte of each product is used downstream.
    logic unused_lsbs;
    assign unused_lsbs = ^{s_rem_prod[7:0], s_nrem_prod[7:0], v_sinv_prod[7:0],
                           q_prod[7:0], t_prod[7:0]};

    assign out_valid = valid_sr[LAT-1];
    assign sec_c     = hsv_sector(s1_h);

    // Valid shift register; reset discards every in-flight sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_sr <= '0;
        end else begin
            valid_sr <= {valid_sr[LAT-2:0], in_valid};
        end
    end

    // Tag delay line; final stage is the out_tag output register.
    always_ff @(posedge clock) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < LAT - 1; i++) begin
            tag_sr[i] <= tag_sr[i-1];
        end
    end

    // S1/S2 datapath registers
    always_ff @(posedge clock) begin
        s1_h       <= h;
        s1_s       <= s;
        s1_v       <= v;
        s2_v       <= s1_v;
        s2_s       <= s1_s;
        s2_s_inv   <= PIX_W'(8'd255 - s1_s);
        s2_rem     <= sec_c.rem;
        s2_rem_inv <= PIX_W'(8'd255 - sec_c.rem);
        s2_region  <= sec_c.region;
        s2_zero    <= (s1_s == '0);
    end

    // S3: s*rem, s*(255-rem), v*(255-s)
    umul8x8 u_mul_srem  (.clock(clock), .a(s2_s), .b(s2_rem),     .p(s_rem_prod));
    umul8x8 u_mul_snrem (.clock(clock), .a(s2_s), .b(s2_rem_inv), .p(s_nrem_prod));
    umul8x8 u_mul_vsinv (.clock(clock), .a(s2_v), .b(s2_s_inv),   .p(v_sinv_prod));

    always_ff @(posedge clock) begin
        s3_v      <= s2_v;
        s3_region <= s2_region;
        s3_zero   <= s2_zero;
    end

    // S4: q and t products; p is the high byte of v*(255-s)
    umul8x8 u_mul_q (.clock(clock), .a(s3_v), .b(PIX_W'(8'd255 - s_rem_prod[15:8])),  .p(q_prod));
    umul8x8 u_mul_t (.clock(clock), .a(s3_v), .b(PIX_W'(8'd255 - s_nrem_prod[15:8])), .p(t_prod));

    always_ff @(posedge clock) begin
        s4_v      <= s3_v;
        s4_p      <= v_sinv_prod[15:8];
        s4_region <= s3_region;
        s4_zero   <= s3_zero;
    end

    // S5 region mux; zero saturation forces grey.
    always_comb begin
        r_c = s4_v;
        g_c = s4_v;
        b_c = s4_v;
        q_c = q_prod[15:8];
        t_c = t_prod[15:8];
        if (!s4_zero) begin
            case (s4_region)
                3'd0:    begin r_c = s4_v; g_c = t_c;  b_c = s4_p; end
                3'd1:    begin r_c = q_c;  g_c = s4_v; b_c = s4_p; end
                3'd2:    begin r_c = s4_p; g_c = s4_v; b_c = t_c;  end
                3'd3:    begin r_c = s4_p; g_c = q_c;  b_c = s4_v; end
                3'd4:    begin r_c = t_c;  g_c = s4_p; b_c = s4_v; end
                default: begin r_c = s4_v; g_c = s4_p; b_c = q_c;  end
            endcase
        end
    end

    // Output registers load only for valid samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            r       <= '0;
            g       <= '0;
            b       <= '0;
            out_tag <= '0;
        end else if (valid_sr[LAT-2]) begin
            r       <= r_c;
            g       <= g_c;
            b       <= b_c;
            out_tag <= tag_sr[LAT-2];
        end
    end

endmodule

// File: tb/tb_hsv2rgb.sv
// Scoreboard bench for hsv2rgb: driver pushes expected pixels, monitor pops/compares.
module tb_hsv2rgb;

    localparam int unsigned TAG_W = 21;

    logic             clock = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       h, s, v;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic [7:0]       r, g, b;
    logic [TAG_W-1:0] out_tag;

    hsv2rgb #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .h(h), .s(s), .v(v), .in_tag(in_tag),
        .out_valid(out_valid), .r(r), .g(g), .b(b), .out_tag(out_tag)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]       r, g, b;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             e_mon;
    int               errors = 0;
    int               checks = 0;
    int               cyc = 0;
    bit               mon_en = 1'b0;
    logic [7:0]       last_r = '0, last_g = '0, last_b = '0;
    logic [TAG_W-1:0] last_tag = '0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every output cycle is either a scored pixel or a hold check.
    always @(posedge clock) begin
        #1;
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 at cycle %0d, expected no output", cyc);
                end else begin
                    e_mon = sb.pop_front();
                    if ({r, g, b, out_tag} !== {e_mon.r, e_mon.g, e_mon.b, e_mon.tag} || cyc != e_mon.cyc) begin
                        errors++;
                        $display("FAIL pixel: got rgb=(%0d,%0d,%0d) tag=%0h cyc=%0d, expected rgb=(%0d,%0d,%0d) tag=%0h cyc=%0d",
                                 r, g, b, out_tag, cyc, e_mon.r, e_mon.g, e_mon.b, e_mon.tag, e_mon.cyc);
                    end
                    last_r = e_mon.r; last_g = e_mon.g; last_b = e_mon.b; last_tag = e_mon.tag;
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0 || {r, g, b, out_tag} !== {last_r, last_g, last_b, last_tag}) begin
                    errors++;
                    $display("FAIL hold: got valid=%b rgb=(%0d,%0d,%0d) tag=%0h, expected valid=0 rgb=(%0d,%0d,%0d) tag=%0h",
                             out_valid, r, g, b, out_tag, last_r, last_g, last_b, last_tag);
                end
            end
        end
    end

    // Independent reference: sector by division.
    function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int vv);
        int region, rem, p, q, t;
        region = hh / 43;
        rem    = ((hh - 43 * region) * 6) % 256;
        p      = (vv * (255 - ss)) >> 8;
        q      = (vv * (255 - ((ss * rem) >> 8))) >> 8;
        t      = (vv * (255 - ((ss * (255 - rem)) >> 8))) >> 8;
        if (ss == 0) return {8'(vv), 8'(vv), 8'(vv)};
        case (region)
            0:       return {8'(vv), 8'(t), 8'(p)};
            1:       return {8'(q), 8'(vv), 8'(p)};
            2:       return {8'(p), 8'(vv), 8'(t)};
            3:       return {8'(p), 8'(q), 8'(vv)};
            4:       return {8'(t), 8'(p), 8'(vv)};
            default: return {8'(vv), 8'(p), 8'(q)};
        endcase
    endfunction

    task automatic send(input logic [7:0] hh, input logic [7:0] ss, input logic [7:0] vv,
                        input logic [TAG_W-1:0] tg,
                        input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
        @(negedge clock);
        reset = 1'b0; in_valid = 1'b1; h = hh; s = ss; v = vv; in_tag = tg;
        sb.push_back('{r: er, g: eg, b: eb, tag: tg, cyc: cyc + 5});
    endtask

    task automatic send_ref(input logic [7:0] hh, input logic [7:0] ss, input logic [7:0] vv,
                            input logic [TAG_W-1:0] tg);
        logic [23:0] x;
        x = ref_rgb(int'(hh), int'(ss), int'(vv));
        send(hh, ss, vv, tg, x[23:16], x[15:8], x[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            reset = 1'b0; in_valid = 1'b0;
            h = 8'($urandom); s = 8'($urandom); v = 8'($urandom); in_tag = TAG_W'($urandom);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({out_valid, r, g, b, out_tag} !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b rgb=(%0d,%0d,%0d) tag=%0h, expected all zero",
                     name, out_valid, r, g, b, out_tag);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0;
        sb.delete();
        last_r = '0; last_g = '0; last_b = '0; last_tag = '0;
        @(posedge clock); #1;
        check_reset_state("mid_reset");
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; h = '0; s = '0; v = '0; in_tag = '0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset_state");
        mon_en = 1'b1;

        // Directed corners with hand-computed results
        send(8'd0,   8'd255, 8'd255, 21'h00001, 8'd255, 8'd0,   8'd0);
        idle(6);
        send(8'd43,  8'd255, 8'd255, 21'h00002, 8'd254, 8'd255, 8'd0);
        send(8'd85,  8'd255, 8'd255, 21'h00003, 8'd3,   8'd255, 8'd0);
        send(8'd255, 8'd255, 8'd200, 21'h00004, 8'd200, 8'd0,   8'd12);
        send(8'd128, 8'd255, 8'd255, 21'h00005, 8'd0,   8'd255, 8'd252);
        idle(1);
        send(8'd170, 8'd255, 8'd255, 21'h00006, 8'd0,   8'd9,   8'd255);
        send(8'd172, 8'd255, 8'd255, 21'h00007, 8'd0,   8'd0,   8'd255);
        send(8'd0,   8'd128, 8'd200, 21'h00008, 8'd200, 8'd100, 8'd99);
        send(8'd200, 8'd0,   8'd77,  21'h1FFFFF, 8'd77, 8'd77,  8'd77);
        idle(8);

        // Grey sweep: s=0 over every hue, back-to-back
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 8'd0, 8'd128, TAG_W'(i), 8'd128, 8'd128, 8'd128);
        end
        idle(8);

        // Reset mid-stream: valid 1,0,(reset),1,1
        send(8'd0, 8'd255, 8'd255, 21'h0AAAA, 8'd255, 8'd0, 8'd0);
        idle(1);
        do_reset();
        send(8'd43, 8'd255, 8'd255, 21'h0BBBB, 8'd254, 8'd255, 8'd0);
        send(8'd85, 8'd255, 8'd255, 21'h0CCCC, 8'd3,   8'd255, 8'd0);
        idle(8);

        // Random samples with random bubbles against the reference
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
            send_ref(8'($urandom), 8'($urandom), 8'($urandom), TAG_W'($urandom));
        end
        idle(1);

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clock);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d samples still pending, expected 0", sb.size());
        end
        idle(4);
        @(posedge clock); #2;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
